// File: rtl/alu_sched_pkg.sv
// alu_sched_pkg: shared definitions for the ALU scheduler.
//   - ALU operation encodings as seen on reqX_op and alu_op
//   - scheduler FSM state type
//   - is_multicycle(): true for ops that use the BEGIN/END handshake
package alu_sched_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  // MUL and DIV share the upper encoding bit, so one bit picks the path.
  function automatic logic is_multicycle(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/alu_sched_rr_arb2.sv
// rr_arb2: combinational two-way round-robin arbiter.
// Ports:
//   valid[1:0]  requests from requester 0 and 1
//   prio        side that wins when both request
//   enable      arbitration allowed (no grant when low)
//   grant[1:0]  one-hot grant, all zero when nothing granted
//   id          index of the winning side
// The priority register lives in the parent so it only advances on an
// actual accept.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       prio,
  input  logic       enable,
  output logic [1:0] grant,
  output logic       id
);

  always_comb begin
    grant = 2'b00;
    id    = 1'b0;
    if (valid[0] && valid[1]) begin
      id = prio;
    end else begin
      id = valid[1];
    end
    if (enable && (|valid)) begin
      grant = id ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/alu_sched.sv
// alu_sched: shares one ALU between two requesters with round-robin
// arbitration and returns the tagged result on a single response channel.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   reqX_valid/ready         request handshake for requester X (0/1)
//   reqX_op/a/m              operation and operands, sampled on accept
//   rsp_valid/ready          response handshake
//   rsp_id/data/err          requester index, ALU OUTBUS, timeout flag
//   alu_begin/op/a/m         drive to the shared ALU
//   alu_end, alu_out         completion and OUTBUS from the ALU
//   busy                     scheduler is not idle
module alu_sched
  import alu_sched_pkg::*;
#(
  parameter int DW      = 8,
  parameter int TIMEOUT = 31
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [1:0]    req0_op,
  input  logic [DW-1:0] req0_a,
  input  logic [DW-1:0] req0_m,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [1:0]    req1_op,
  input  logic [DW-1:0] req1_a,
  input  logic [DW-1:0] req1_m,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_id,
  output logic [2*DW-1:0] rsp_data,
  output logic          rsp_err,
  output logic          alu_begin,
  output logic [1:0]    alu_op,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_m,
  input  logic          alu_end,
  input  logic [2*DW-1:0] alu_out,
  output logic          busy
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t        state, state_nx;
  logic          prio;
  logic [1:0]    hold_op;
  logic [DW-1:0] hold_a;
  logic [DW-1:0] hold_m;
  logic          hold_id;
  logic [CW-1:0] cnt;

  logic [1:0]    grant;
  logic          grant_id;
  logic          accept;
  logic          timed_out;
  logic [1:0]    sel_op;
  logic [DW-1:0] sel_a;
  logic [DW-1:0] sel_m;

  rr_arb2 u_arb (
    .valid  ({req1_valid, req0_valid}),
    .prio   (prio),
    .enable (state == IDLE),
    .grant  (grant),
    .id     (grant_id)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign accept     = |grant;
  assign busy       = (state != IDLE);
  assign rsp_valid  = (state == RESP);

  // The ALU inputs come straight from the hold registers, so they stay
  // stable from EXEC through WAIT without a separate output stage.
  assign alu_op = hold_op;
  assign alu_a  = hold_a;
  assign alu_m  = hold_m;

  assign sel_op = grant_id ? req1_op : req0_op;
  assign sel_a  = grant_id ? req1_a  : req0_a;
  assign sel_m  = grant_id ? req1_m  : req0_m;

  // The counter starts at 0 in the first WAIT cycle, so comparing with
  // TIMEOUT-1 gives exactly TIMEOUT cycles spent in WAIT.
  assign timed_out = (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // A completing alu_end takes precedence over a coincident timeout.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = EXEC;
      EXEC: state_nx = is_multicycle(hold_op) ? WAIT : RESP;
      WAIT: if (alu_end || timed_out) state_nx = RESP;
      RESP: if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio      <= 1'b0;
      hold_op   <= 2'b00;
      hold_a    <= '0;
      hold_m    <= '0;
      hold_id   <= 1'b0;
      cnt       <= '0;
      alu_begin <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            hold_op   <= sel_op;
            hold_a    <= sel_a;
            hold_m    <= sel_m;
            hold_id   <= grant_id;
            prio      <= ~grant_id;
            // Raised on accept so BEGIN is already high during EXEC.
            alu_begin <= is_multicycle(sel_op);
          end
        end
        EXEC: begin
          cnt <= '0;
          if (!is_multicycle(hold_op)) begin
            rsp_data <= alu_out;
            rsp_err  <= 1'b0;
            rsp_id   <= hold_id;
          end
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (alu_end) begin
            rsp_data  <= alu_out;
            rsp_err   <= 1'b0;
            rsp_id    <= hold_id;
            alu_begin <= 1'b0;
          end else if (timed_out) begin
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
            rsp_id    <= hold_id;
            alu_begin <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sched.sv
// tb_alu_sched: self-checking bench for alu_sched with a behavioural ALU
// stub and a transaction-level reference for arbitration, latency and
// results.
module tb_alu_sched;
  import alu_sched_pkg::*;

  localparam int DW      = 8;
  localparam int TIMEOUT = 31;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req0_ready;
  logic [1:0]    req0_op;
  logic [DW-1:0] req0_a, req0_m;
  logic          req1_valid, req1_ready;
  logic [1:0]    req1_op;
  logic [DW-1:0] req1_a, req1_m;
  logic          rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [2*DW-1:0] rsp_data;
  logic          alu_begin, alu_end, busy;
  logic [1:0]    alu_op;
  logic [DW-1:0] alu_a, alu_m;
  logic [2*DW-1:0] alu_out;

  int total = 0;
  int bad   = 0;

  bit   deadAlu    = 1'b0;
  bit   aluRunning = 1'b0;
  int   aluDelay   = 0;
  int   maxDelay   = 4;
  logic aluEndReg  = 1'b0;
  bit   modelPrio  = 1'b0;

  always #5 clk = ~clk;

  alu_sched #(.DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_m     (req0_m),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_m     (req1_m),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .alu_begin  (alu_begin),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_m      (alu_m),
    .alu_end    (alu_end),
    .alu_out    (alu_out),
    .busy       (busy)
  );

  // Reference ALU arithmetic: DIV packs remainder high, quotient low.
  function automatic logic [15:0] aluRef(input logic [1:0] op, input logic [7:0] a, input logic [7:0] m);
    case (op)
      OP_ADD:  return 16'(a) + 16'(m);
      OP_SUB:  return 16'(a) - 16'(m);
      OP_MUL:  return 16'(a) * 16'(m);
      default: return (m == 8'd0) ? {a, 8'hFF} : {a % m, a / m};
    endcase
  endfunction

  // Multi-cycle results are only visible while END is high, so a capture
  // at the wrong moment picks up the filler value instead.
  assign alu_end = aluEndReg;
  assign alu_out = (alu_op[1] && !aluEndReg) ? 16'hDEAD : aluRef(alu_op, alu_a, alu_m);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      aluRunning = 1'b0;
      aluEndReg  = 1'b0;
    end else begin
      #1;
      if (aluEndReg) begin
        aluEndReg  = 1'b0;
        aluRunning = 1'b0;
      end else if (aluRunning && !alu_begin) begin
        aluRunning = 1'b0;
      end else if (aluRunning) begin
        aluDelay = aluDelay - 1;
        if (aluDelay == 0 && !deadAlu) aluEndReg = 1'b1;
      end else if (alu_begin) begin
        aluRunning = 1'b1;
        aluDelay   = $urandom_range(maxDelay, 1);
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Serves every requested operation, predicting the arbitration order,
  // the response latency and the returned value for each one.
  task automatic applyStimulus(input bit v0, input logic [1:0] op0, input logic [7:0] a0, input logic [7:0] m0,
                               input bit v1, input logic [1:0] op1, input logic [7:0] a1, input logic [7:0] m1,
                               input int bp);
    bit         pend [2];
    logic [1:0] opS  [2];
    logic [7:0] aS   [2];
    logic [7:0] mS   [2];
    pend[0] = v0; opS[0] = op0; aS[0] = a0; mS[0] = m0;
    pend[1] = v1; opS[1] = op1; aS[1] = a1; mS[1] = m1;
    req0_op = op0; req0_a = a0; req0_m = m0;
    req1_op = op1; req1_a = a1; req1_m = m1;
    while (pend[0] || pend[1]) begin
      int w, c, endCycle, expLat;
      bit got, multi, expErr;
      logic [15:0] expData;
      req0_valid = pend[0];
      req1_valid = pend[1];
      @(negedge clk);
      w = (pend[0] && pend[1]) ? int'(modelPrio) : (pend[1] ? 1 : 0);
      checkOutput("ready0", req0_ready, w == 0);
      checkOutput("ready1", req1_ready, w == 1);
      checkOutput("idleBusy", busy, 0);
      @(posedge clk); #1;
      pend[w]   = 1'b0;
      modelPrio = (w == 0);
      // Drop the winner and scramble its operands; the other side stays up.
      if (w == 0) begin
        req0_valid = 1'b0; req0_a = 8'($urandom); req0_m = 8'($urandom);
      end else begin
        req1_valid = 1'b0; req1_a = 8'($urandom); req1_m = 8'($urandom);
      end
      multi    = opS[w][1];
      expErr   = multi && deadAlu;
      expData  = expErr ? 16'h0 : aluRef(opS[w], aS[w], mS[w]);
      c        = 0;
      endCycle = -1;
      got      = 1'b0;
      while (!got && c < 60) begin
        @(negedge clk);
        c++;
        if (rsp_valid) begin
          got = 1'b1;
        end else begin
          checkOutput("busyRun", busy, 1);
          checkOutput("noGrantRun", {req1_ready, req0_ready}, 0);
          checkOutput("beginRun", alu_begin, multi);
          if (alu_end) endCycle = c;
        end
      end
      if (!got) begin
        checkOutput("rspBound", 0, 1);
        return;
      end
      if (!multi)       expLat = 2;
      else if (deadAlu) expLat = TIMEOUT + 2;
      else              expLat = endCycle + 1;
      checkOutput("latency", c, expLat);
      checkOutput("rspId", rsp_id, w);
      checkOutput("rspData", rsp_data, expData);
      checkOutput("rspErr", rsp_err, expErr);
      checkOutput("beginResp", alu_begin, 0);
      for (int k = 0; k < bp; k++) begin
        @(negedge clk);
        checkOutput("bpValid", rsp_valid, 1);
        checkOutput("bpId", rsp_id, w);
        checkOutput("bpData", rsp_data, expData);
        checkOutput("bpErr", rsp_err, expErr);
        checkOutput("bpNoGrant", {req1_ready, req0_ready}, 0);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
    end
    @(negedge clk);
    checkOutput("doneValid", rsp_valid, 0);
    checkOutput("doneBusy", busy, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog expired got=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1; rsp_ready = 1'b0;
    req0_valid = 1'b0; req0_op = 2'b00; req0_a = '0; req0_m = '0;
    req1_valid = 1'b0; req1_op = 2'b00; req1_a = '0; req1_m = '0;
    repeat (3) @(negedge clk);
    checkOutput("rstValid", rsp_valid, 0);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstBegin", alu_begin, 0);
    checkOutput("rstData", rsp_data, 0);
    checkOutput("rstIdErr", {rsp_id, rsp_err}, 0);
    checkOutput("rstAluIn", {alu_op, alu_a, alu_m}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    applyStimulus(1, OP_ADD, 8'd27, 8'd20, 0, OP_ADD, 8'd0, 8'd0, 0);
    applyStimulus(0, OP_ADD, 8'd0, 8'd0, 1, OP_SUB, 8'd40, 8'd33, 0);
    applyStimulus(1, OP_MUL, 8'd15, 8'd3, 0, OP_ADD, 8'd0, 8'd0, 0);
    applyStimulus(1, OP_DIV, 8'd100, 8'd3, 1, OP_ADD, 8'd5, 8'd6, 0);
    applyStimulus(1, OP_DIV, 8'd100, 8'd3, 1, OP_ADD, 8'd5, 8'd6, 1);

    deadAlu = 1'b1;
    applyStimulus(1, OP_MUL, 8'd4, 8'd4, 0, OP_ADD, 8'd0, 8'd0, 0);
    deadAlu = 1'b0;
    applyStimulus(1, OP_ADD, 8'd1, 8'd1, 0, OP_ADD, 8'd0, 8'd0, 0);
    applyStimulus(0, OP_ADD, 8'd0, 8'd0, 1, OP_MUL, 8'd200, 8'd200, 5);

    // Reset while the ALU is stalled in WAIT; priority must return to 0.
    deadAlu = 1'b1;
    req0_op = OP_MUL; req0_a = 8'd9; req0_m = 8'd9; req0_valid = 1'b1;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("preRstBegin", alu_begin, 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("midRstBegin", alu_begin, 0);
    checkOutput("midRstValid", rsp_valid, 0);
    checkOutput("midRstBusy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    deadAlu   = 1'b0;
    modelPrio = 1'b0;
    @(posedge clk); #1;
    applyStimulus(1, OP_ADD, 8'd2, 8'd3, 1, OP_SUB, 8'd3, 8'd9, 0);

    for (int i = 0; i < 40; i++) begin
      bit rv0, rv1;
      rv0 = 1'($urandom);
      rv1 = 1'($urandom);
      if (!rv0 && !rv1) rv0 = 1'b1;
      maxDelay = $urandom_range(8, 1);
      applyStimulus(rv0, 2'($urandom), 8'($urandom), 8'($urandom),
                    rv1, 2'($urandom), 8'($urandom), 8'($urandom),
                    $urandom_range(3, 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
